// File: rtl/uart_io_bridge.sv
// Buffered UART front end: TX and RX FIFOs between the core I/O bus and buart,
// running the buart wr/rd/valid/busy handshakes and exposing one status/data word.
module uart_io_bridge #(
  parameter int DEPTH   = 16,
  parameter int CLKFREQ = 100000000
) (
  input  logic        clock,
  input  logic        active_low_reset,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [7:0]  io_wdata,
  output logic [15:0] io_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_wr,
  input  logic        uart_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_valid,
  output logic        uart_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TX = 0;
  localparam int RX = 1;
  localparam logic [15:0] ADDR_TX_PUSH = 16'h00F0;
  localparam logic [15:0] ADDR_RX_POP  = 16'h00F1;
  localparam logic [15:0] ADDR_CLEAR   = 16'h00F2;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLKFREQ <= 0) begin : g_bad_params
      $error("uart_io_bridge: DEPTH must be a power of two >= 2 and CLKFREQ positive");
    end
  endgenerate

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_HOLD} rx_state_t;

  tx_state_t       tx_state_reg;
  rx_state_t       rx_state_reg;
  logic            tx_drop_reg;
  logic            rx_overrun_reg;

  logic [1:0]      fifo_push;
  logic [1:0]      fifo_pop;
  logic [1:0]      fifo_empty;
  logic [1:0]      fifo_full;
  logic [1:0][7:0] fifo_wdata;
  logic [1:0][7:0] fifo_head;

  logic            bus_tx_push;
  logic            bus_rx_pop;
  logic            bus_clear;
  logic            tx_start;
  logic            rx_capture;

  // Index 0 is the TX FIFO, index 1 the RX FIFO; both share one circular-buffer shape.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;

      always_ff @(posedge clock) begin
        if (fifo_push[gi]) mem[wr_ptr_reg] <= fifo_wdata[gi];
      end

      always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          if (fifo_push[gi] && !fifo_pop[gi])
            count_reg <= count_reg + CW'(1);
          else if (fifo_pop[gi] && !fifo_push[gi])
            count_reg <= count_reg - CW'(1);
        end
      end

      assign fifo_head[gi]  = mem[rd_ptr_reg];
      assign fifo_empty[gi] = (count_reg == '0);
      assign fifo_full[gi]  = (count_reg == CW'(DEPTH));
    end
  endgenerate

  assign bus_tx_push = io_write_enable && (io_address == ADDR_TX_PUSH);
  assign bus_rx_pop  = io_write_enable && (io_address == ADDR_RX_POP);
  assign bus_clear   = io_write_enable && (io_address == ADDR_CLEAR);

  assign tx_start   = (tx_state_reg == TX_IDLE) && !fifo_empty[TX] && !uart_busy;
  assign rx_capture = (rx_state_reg == RX_IDLE) && uart_valid;

  // A full FIFO still accepts a push when a pop frees the slot on the same edge.
  assign fifo_wdata[TX] = io_wdata;
  assign fifo_pop[TX]   = tx_start;
  assign fifo_push[TX]  = bus_tx_push && (!fifo_full[TX] || tx_start);
  assign fifo_wdata[RX] = uart_rx_data;
  assign fifo_pop[RX]   = bus_rx_pop && !fifo_empty[RX];
  assign fifo_push[RX]  = rx_capture && (!fifo_full[RX] || fifo_pop[RX]);

  // Sticky flags: a set on the same edge as a clear wins.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      tx_drop_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (bus_tx_push && fifo_full[TX] && !tx_start)
        tx_drop_reg <= 1'b1;
      else if (bus_clear && io_wdata[1])
        tx_drop_reg <= 1'b0;
      if (rx_capture && fifo_full[RX] && !fifo_pop[RX])
        rx_overrun_reg <= 1'b1;
      else if (bus_clear && io_wdata[0])
        rx_overrun_reg <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      tx_state_reg <= TX_IDLE;
      uart_wr      <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_start) begin
            uart_tx_data <= fifo_head[TX];
            uart_wr      <= 1'b1;
            tx_state_reg <= TX_SEND;
          end
        end
        TX_SEND: begin
          uart_wr      <= 1'b0;
          tx_state_reg <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: if (uart_busy)  tx_state_reg <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!uart_busy) tx_state_reg <= TX_IDLE;
        default: begin
          uart_wr      <= 1'b0;
          tx_state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  // RX_HOLD waits for valid to drop so a held byte is never captured twice.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      rx_state_reg <= RX_IDLE;
      uart_rd      <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_capture) begin
            uart_rd      <= 1'b1;
            rx_state_reg <= RX_ACK;
          end
        end
        RX_ACK: begin
          uart_rd      <= 1'b0;
          rx_state_reg <= RX_HOLD;
        end
        RX_HOLD: if (!uart_valid) rx_state_reg <= RX_IDLE;
        default: begin
          uart_rd      <= 1'b0;
          rx_state_reg <= RX_IDLE;
        end
      endcase
    end
  end

  assign io_rdata = {(fifo_empty[RX] ? 8'h00 : fifo_head[RX]),
                     3'b000,
                     tx_drop_reg,
                     fifo_empty[TX],
                     rx_overrun_reg,
                     fifo_full[TX],
                     !fifo_empty[RX]};

endmodule

// File: tb/tb_uart_io_bridge.sv
// Bench for uart_io_bridge: buart models on both sides, a TX byte scoreboard
// drained by a monitor, and a queue-based RX reference model.
module tb_uart_io_bridge;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        active_low_reset;
  logic        io_write_enable;
  logic [15:0] io_address;
  logic [7:0]  io_wdata;
  logic [15:0] io_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_wr;
  logic        uart_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_valid;
  logic        uart_rd;

  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  int         rd_count = 0;
  int         busy_len = 3;
  logic       model_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] rx_q[$];

  assign uart_busy = model_busy | hold_busy;

  always #5 clock = ~clock;

  uart_io_bridge #(.DEPTH(DEPTH), .CLKFREQ(100000000)) dut (
    .clock           (clock),
    .active_low_reset(active_low_reset),
    .io_write_enable (io_write_enable),
    .io_address      (io_address),
    .io_wdata        (io_wdata),
    .io_rdata        (io_rdata),
    .uart_tx_data    (uart_tx_data),
    .uart_wr         (uart_wr),
    .uart_busy       (uart_busy),
    .uart_rx_data    (uart_rx_data),
    .uart_valid      (uart_valid),
    .uart_rd         (uart_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // buart transmitter: busy rises one cycle after a wr pulse and lasts busy_len cycles.
  initial begin : buart_tx_model
    forever begin
      @(negedge clock);
      if (uart_wr) begin
        @(negedge clock);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clock);
        model_busy = 1'b0;
      end
    end
  end

  initial begin : tx_monitor
    logic       prev_wr;
    logic [7:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clock);
      if (uart_wr) begin
        wr_count++;
        check("tx_wr_single_cycle", prev_wr, 0);
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_byte: got 0x%02h, expected no transmission", uart_tx_data);
        end else begin
          e = exp_tx_q.pop_front();
          $display("tx byte 0x%02h (expected 0x%02h)", uart_tx_data, e);
          check("tx_byte", uart_tx_data, e);
        end
      end
      prev_wr = uart_wr;
    end
  end

  initial begin : rd_monitor
    logic prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clock);
      if (uart_rd) begin
        rd_count++;
        check("rx_rd_single_cycle", prev_rd, 0);
      end
      prev_rd = uart_rd;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // All bus tasks are entered at a negedge and return at the next negedge.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    io_address      = addr;
    io_wdata        = data;
    io_write_enable = 1'b1;
    @(negedge clock);
    io_write_enable = 1'b0;
    io_address      = 16'h0000;
  endtask

  task automatic tx_push(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) exp_tx_q.push_back(b);
    bus_write(16'h00F0, b);
  endtask

  task automatic rx_pop_check(input string tag);
    logic [7:0] e;
    e = rx_q.pop_front();
    check({tag, "_nonempty"}, io_rdata[0], 1);
    check({tag, "_head"}, io_rdata[15:8], e);
    $display("rx pop 0x%02h (expected 0x%02h)", io_rdata[15:8], e);
    bus_write(16'h00F1, 8'h00);
  endtask

  // buart receiver: hold valid until rd is seen, then drop it.
  task automatic deliver(input logic [7:0] b);
    int n;
    uart_rx_data = b;
    uart_valid   = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!uart_rd && n < 20);
    check("rx_rd_seen", uart_rd, 1);
    check("rx_rd_latency", n, 1);
    uart_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    $display("rx deliver 0x%02h (model depth %0d)", b, rx_q.size());
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (exp_tx_q.size() != 0 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check("tx_drain_done", exp_tx_q.size(), 0);
    repeat (2) @(negedge clock);
    n = 0;
    while (uart_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin : main
    int base;
    int n;
    int delivered;

    active_low_reset = 1'b0;
    io_write_enable  = 1'b0;
    io_address       = 16'h0000;
    io_wdata         = 8'h00;
    uart_rx_data     = 8'h00;
    uart_valid       = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rdata", io_rdata, 16'h0008);
    check("reset_wr", uart_wr, 0);
    check("reset_rd", uart_rd, 0);
    check("reset_tx_data", uart_tx_data, 8'h00);
    active_low_reset = 1'b1;
    @(negedge clock);
    check("idle_rdata", io_rdata, 16'h0008);

    // Single TX with a long busy period.
    busy_len = 20;
    base = wr_count;
    tx_push(8'h41, 1'b1);
    check("tx_not_empty_after_push", io_rdata[3], 0);
    @(negedge clock);
    check("tx_wr_latency", uart_wr, 1);
    check("tx_empty_after_pop", io_rdata[3], 1);
    wait_tx_drain();
    check("tx_single_wr_count", wr_count - base, 1);

    // TX overflow with busy held, then a push on the same edge as the first drain pop.
    hold_busy = 1'b1;
    busy_len  = 2;
    base = wr_count;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tx_push(8'(i), i < DEPTH);
      if (i == DEPTH - 2) check("tx_full_before_last", io_rdata[1], 0);
      if (i == DEPTH - 1) begin
        check("tx_full_at_depth", io_rdata[1], 1);
        check("tx_drop_at_depth", io_rdata[4], 0);
      end
      if (i == DEPTH) begin
        check("tx_drop_on_overflow", io_rdata[4], 1);
        check("tx_full_on_overflow", io_rdata[1], 1);
      end
    end
    check("tx_no_wr_while_busy", wr_count - base, 0);
    bus_write(16'h00F2, 8'h01);
    check("tx_drop_kept_by_rx_clear", io_rdata[4], 1);
    bus_write(16'h00F2, 8'h02);
    check("tx_drop_cleared", io_rdata[4], 0);
    hold_busy = 1'b0;
    tx_push(8'h11, 1'b1);
    check("tx_full_after_simul", io_rdata[1], 1);
    check("tx_drop_after_simul", io_rdata[4], 0);
    wait_tx_drain();
    check("tx_overflow_wr_count", wr_count - base, DEPTH + 1);
    check("tx_empty_after_drain", io_rdata[3], 1);

    // RX path with fixed bytes.
    deliver(8'h55);
    deliver(8'hAA);
    check("rx_word_first", io_rdata, 16'h5509);
    void'(rx_q.pop_front());
    bus_write(16'h00F1, 8'h00);
    check("rx_word_second", io_rdata, 16'hAA09);
    void'(rx_q.pop_front());
    bus_write(16'h00F1, 8'h00);
    check("rx_word_empty", io_rdata, 16'h0008);
    bus_write(16'h00F1, 8'h00);
    check("rx_pop_empty_ignored", io_rdata, 16'h0008);

    // RX overrun: one byte more than the FIFO holds, no pops.
    base = rd_count;
    for (int i = 0; i < DEPTH + 1; i++) deliver(8'($urandom));
    check("rx_overrun_set", io_rdata[2], 1);
    check("rx_rd_pulses", rd_count - base, DEPTH + 1);
    bus_write(16'h00F2, 8'h02);
    check("rx_overrun_kept_by_tx_clear", io_rdata[2], 1);
    while (rx_q.size() > 0) rx_pop_check("rx_overrun_data");
    check("rx_empty_after_drain", io_rdata[0], 0);
    bus_write(16'h00F2, 8'h01);
    check("rx_overrun_cleared", io_rdata[2], 0);

    // RX pointer wrap: random interleaving of deliveries and pops.
    delivered = 0;
    while (delivered < 40 || rx_q.size() > 0) begin
      if (delivered < 40 && rx_q.size() < DEPTH &&
          (rx_q.size() == 0 || $urandom_range(0, 1) == 1)) begin
        deliver(8'($urandom));
        delivered++;
      end else begin
        rx_pop_check("rx_wrap");
      end
    end
    check("rx_wrap_no_overrun", io_rdata[2], 0);
    check("rx_wrap_empty", io_rdata[0], 0);

    // Random TX traffic, never exceeding FIFO capacity.
    base = wr_count;
    for (int i = 0; i < 30; i++) begin
      busy_len = $urandom_range(1, 6);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      n = 0;
      while ((i - (wr_count - base)) >= DEPTH && n < 2000) begin
        @(negedge clock);
        n++;
      end
      tx_push(8'($urandom), 1'b1);
    end
    wait_tx_drain();
    check("tx_random_wr_count", wr_count - base, 30);

    // Non-decoded address has no effect.
    hold_busy = 1'b1;
    bus_write(16'h01F0, 8'hEE);
    check("bad_addr_ignored", io_rdata, 16'h0008);
    hold_busy = 1'b0;
    @(negedge clock);

    // Reset asserted while waiting for busy to fall with three bytes still queued.
    busy_len = 40;
    tx_push(8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) tx_push(8'(8'hD0 + i), 1'b0);
    n = 0;
    while (!uart_busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check("reset_pre_tx_queued", io_rdata[3], 0);
    active_low_reset = 1'b0;
    #1;
    check("reset_async_rdata", io_rdata, 16'h0008);
    check("reset_async_wr", uart_wr, 0);
    check("reset_async_rd", uart_rd, 0);
    check("reset_async_tx_data", uart_tx_data, 8'h00);
    @(negedge clock);
    active_low_reset = 1'b1;
    n = 0;
    while (uart_busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    busy_len = 2;
    tx_push(8'h7E, 1'b1);
    wait_tx_drain();
    check("post_reset_rdata", io_rdata, 16'h0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
